// File: rtl/vga_scan_gen.sv
// VGA raster scan generator with pipeline-aligned sync and registered RGB output.
// Coordinates feed the region decoders; sync/blank are delayed PIPE ticks to meet the returning colour.
module vga_scan_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] color_RGB,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pix_tick,
  output logic        active,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic act;
    logic vs;
    logic hs;
  } pixCtl_t;

  localparam pixCtl_t CTL_IDLE = '{act: 1'b0, vs: 1'b1, hs: 1'b1};

  logic [DIV_W-1:0] divCnt;
  logic [DIV_W-1:0] divNext;
  logic [9:0]       hCnt;
  logic [9:0]       vCnt;
  logic             runQ;
  logic             hsRaw;
  logic             vsRaw;
  pixCtl_t          ctlRaw;
  pixCtl_t          ctlLast;

  always_comb begin
    divNext = (divCnt == DIV_MAX) ? '0 : divCnt + 1'b1;
  end

  // pix_tick is registered from the next divider value so it reads 0 in reset even when CLK_DIV=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt   <= '0;
      pix_tick <= 1'b0;
      runQ     <= 1'b0;
    end else begin
      divCnt   <= divNext;
      pix_tick <= (divNext == DIV_MAX);
      runQ     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hCnt        <= '0;
      vCnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && (hCnt == H_LAST) && (vCnt == V_LAST);
      if (pix_tick) begin
        if (hCnt == H_LAST) begin
          hCnt <= '0;
          vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
        end else begin
          hCnt <= hCnt + 1'b1;
        end
      end
    end
  end

  assign x      = hCnt;
  assign y      = vCnt;
  assign active = runQ && (hCnt < H_ACT) && (vCnt < V_ACT);
  assign hsRaw  = !((hCnt >= H_SYNC_BEG) && (hCnt < H_SYNC_END));
  assign vsRaw  = !((vCnt >= V_SYNC_BEG) && (vCnt < V_SYNC_END));

  always_comb begin
    ctlRaw     = CTL_IDLE;
    ctlRaw.act = active;
    ctlRaw.vs  = vsRaw;
    ctlRaw.hs  = hsRaw;
  end

  generate
    if (PIPE == 0) begin : gNoDly
      assign ctlLast = ctlRaw;
    end else begin : gDly
      pixCtl_t dly [PIPE];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < PIPE; i++) begin
            dly[i] <= CTL_IDLE;
          end
        end else if (pix_tick) begin
          dly[0] <= ctlRaw;
          for (int unsigned i = 1; i < PIPE; i++) begin
            dly[i] <= dly[i-1];
          end
        end
      end

      assign ctlLast = dly[PIPE-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      rgb_out <= '0;
    end else if (pix_tick) begin
      hsync   <= ctlLast.hs;
      vsync   <= ctlLast.vs;
      rgb_out <= ctlLast.act ? color_RGB : '0;
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Randomized bench for vga_scan_gen: two small-raster instances checked against a tick-count model.
module tb_vga_scan_gen;

  localparam int NI = 2;
  localparam int CDIV [NI] = '{2, 1};
  localparam int PIPES[NI] = '{2, 0};
  localparam int HA   [NI] = '{8, 8};
  localparam int HF   [NI] = '{2, 1};
  localparam int HS   [NI] = '{3, 2};
  localparam int HB   [NI] = '{2, 1};
  localparam int VA   [NI] = '{5, 4};
  localparam int VF   [NI] = '{1, 1};
  localparam int VS   [NI] = '{2, 1};
  localparam int VB   [NI] = '{1, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] color;

  logic [9:0]  xO   [NI];
  logic [9:0]  yO   [NI];
  logic        tickO[NI];
  logic        actO [NI];
  logic        fsO  [NI];
  logic        hsO  [NI];
  logic        vsO  [NI];
  logic [23:0] rgbO [NI];

  int          k    [NI];
  int          n    [NI];
  logic [23:0] rgbE [NI];
  logic        fsE  [NI];

  int total;
  int bad;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : gDut
      vga_scan_gen #(
        .CLK_DIV (CDIV[g]),
        .H_ACTIVE(HA[g]),
        .H_FP    (HF[g]),
        .H_SYNC  (HS[g]),
        .H_BP    (HB[g]),
        .V_ACTIVE(VA[g]),
        .V_FP    (VF[g]),
        .V_SYNC  (VS[g]),
        .V_BP    (VB[g]),
        .PIPE    (PIPES[g])
      ) dut (
        .clk        (clk),
        .rst        (rst),
        .color_RGB  (color),
        .x          (xO[g]),
        .y          (yO[g]),
        .pix_tick   (tickO[g]),
        .active     (actO[g]),
        .frame_start(fsO[g]),
        .hsync      (hsO[g]),
        .vsync      (vsO[g]),
        .rgb_out    (rgbO[g])
      );
    end
  endgenerate

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int hTot(int u);
    return HA[u] + HF[u] + HS[u] + HB[u];
  endfunction

  function automatic int frameLen(int u);
    return hTot(u) * (VA[u] + VF[u] + VS[u] + VB[u]);
  endfunction

  function automatic bit visible(int u, int p);
    return (p % hTot(u)) < HA[u] && (p / hTot(u)) < VA[u];
  endfunction

  function automatic bit hsLevel(int u, int p);
    int h = p % hTot(u);
    return !(h >= HA[u] + HF[u] && h < HA[u] + HF[u] + HS[u]);
  endfunction

  function automatic bit vsLevel(int u, int p);
    int v = p / hTot(u);
    return !(v >= VA[u] + VF[u] && v < VA[u] + VF[u] + VS[u]);
  endfunction

  function automatic bit tickAt(int u, int kk);
    return kk >= 1 && (kk % CDIV[u]) == CDIV[u] - 1;
  endfunction

  // k counts clocks since reset released; n counts completed pixel ticks.
  task automatic modelEdge();
    for (int u = 0; u < NI; u++) begin
      if (rst) begin
        k[u] = 0; n[u] = 0; rgbE[u] = '0; fsE[u] = 1'b0;
      end else begin
        fsE[u] = 1'b0;
        if (tickAt(u, k[u])) begin
          int m = n[u] - PIPES[u];
          rgbE[u] = (m >= 0 && visible(u, m % frameLen(u))) ? color : 24'h0;
          n[u]++;
          fsE[u] = (n[u] % frameLen(u)) == 0;
        end
        k[u]++;
      end
    end
  endtask

  task automatic checkAll();
    for (int u = 0; u < NI; u++) begin
      int pos = n[u] % frameLen(u);
      int m2  = n[u] - 1 - PIPES[u];
      bit hsE = (m2 >= 0) ? hsLevel(u, m2 % frameLen(u)) : 1'b1;
      bit vsE = (m2 >= 0) ? vsLevel(u, m2 % frameLen(u)) : 1'b1;
      checkEq($sformatf("x%0d", u),     32'(xO[u]),    32'(pos % hTot(u)));
      checkEq($sformatf("y%0d", u),     32'(yO[u]),    32'(pos / hTot(u)));
      checkEq($sformatf("tick%0d", u),  32'(tickO[u]), 32'(tickAt(u, k[u])));
      checkEq($sformatf("active%0d", u), 32'(actO[u]), 32'(k[u] >= 1 && visible(u, pos)));
      checkEq($sformatf("fstart%0d", u), 32'(fsO[u]),  32'(fsE[u]));
      checkEq($sformatf("hsync%0d", u), 32'(hsO[u]),   32'(hsE));
      checkEq($sformatf("vsync%0d", u), 32'(vsO[u]),   32'(vsE));
      checkEq($sformatf("rgb%0d", u),   32'(rgbO[u]),  32'(rgbE[u]));
    end
  endtask

  initial begin
    int rstHold;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    color   = '0;
    rstHold = 3;
    for (int u = 0; u < NI; u++) begin
      k[u] = 0; n[u] = 0; rgbE[u] = '0; fsE[u] = 1'b0;
    end
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkAll();
      if (rstHold > 0) begin
        rstHold--;
        rst = 1'b1;
      end else if (c < 3000 && $urandom_range(0, 499) == 0) begin
        rstHold = int'($urandom_range(0, 2));
        rst = 1'b1;
      end else begin
        rst = 1'b0;
      end
      color = 24'($urandom());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
